axil_scope_sample_regs: RTL and testbench

AXI4-Lite responder (slave) exposing an XADC sample buffer to the PS, the counterpart of the AXI4-Lite initiator that drives the scope IP register bank. XADC samples arrive on a valid/data strobe, are buffered in a small FIFO, and are read out through a 4-word register map. The block sits between the XADC capture path and the PS interconnect. It raises a level interrupt when the buffered sample count reaches a programmable threshold.

---
 rtl/axil_scope_pkg.sv | 13 +
 rtl/scope_sample_fifo.sv | 39 +++
 rtl/axil_scope_sample_regs.sv | 112 +++++++++++
 tb/tb_axil_scope_sample_regs.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/axil_scope_pkg.sv
// axil_scope_pkg: register offsets, CTRL/STATUS bit indices and response codes for the scope sample register block
package axil_scope_pkg;
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_THRESH = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_DATA = 2'd3;
  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_FLUSH_BIT = 1;
  localparam int STAT_OVF_BIT = 16;
  localparam int STAT_EMPTY_BIT = 17;
  localparam int STAT_FULL_BIT = 18;
  localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/scope_sample_fifo.sv
// scope_sample_fifo: sync FIFO (clk, rst, push/pop/flush, din -> dout, level, empty, full); push while full only lands if a pop frees a slot on the same edge
module scope_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic do_push, do_pop;
  assign level = wptr - rptr;
  assign empty = level == '0;
  assign full = level == FULL_LVL;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/axil_scope_sample_regs.sv
// axil_scope_sample_regs: AXI4-Lite slave (ACLK, ARESET, S_AXI_*) exposing CTRL/THRESH/STATUS/DATA over a sample FIFO (sample_valid, sample_data) with level irq fifo_irq; AXIL_SCOPE_WSTRB_EN enables byte-lane writes
module axil_scope_sample_regs
  import axil_scope_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int SAMPLE_WIDTH = 12
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  input  logic                          sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]       sample_data,
  output logic                          fifo_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic aw_rdy, ar_rdy, bvalid, rvalid, en, ovf, irq;
  logic empty, full, wr_hs, rd_hs, pop, push_req, flush;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata, rd_mux, status;
  logic [AW:0] thresh, level, wmask;
  logic [SAMPLE_WIDTH-1:0] dout;
  logic [1:0] wsel, rsel;
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_WSTRB};
  assign wsel = S_AXI_AWADDR[3:2];
  assign rsel = S_AXI_ARADDR[3:2];
  assign wr_hs = aw_rdy && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_hs = ar_rdy && S_AXI_ARVALID;
  assign pop = rd_hs && rsel == REG_DATA && !empty;
  assign push_req = sample_valid && en;
`ifdef AXIL_SCOPE_WSTRB_EN
  always_comb
    for (int i = 0; i <= AW; i++) wmask[i] = S_AXI_WSTRB[i/8];
`else
  assign wmask = '1;
`endif
  assign flush = wr_hs && wsel == REG_CTRL && wmask[CTRL_FLUSH_BIT] && S_AXI_WDATA[CTRL_FLUSH_BIT];
  always_comb begin
    status = '0;
    status[15:0] = 16'(level);
    status[STAT_OVF_BIT] = ovf;
    status[STAT_EMPTY_BIT] = empty;
    status[STAT_FULL_BIT] = full;
  end
  assign rd_mux = rsel == REG_CTRL ? 32'(en) :
                  rsel == REG_THRESH ? 32'(thresh) :
                  rsel == REG_STATUS ? status :
                  empty ? '0 : {1'b1, 15'b0, 16'(dout)};
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_rdy <= 1'b0;
      bvalid <= 1'b0;
      ar_rdy <= 1'b0;
      rvalid <= 1'b0;
      rdata <= '0;
      en <= 1'b0;
      thresh <= '0;
      ovf <= 1'b0;
      irq <= 1'b0;
    end else begin
      aw_rdy <= !aw_rdy && S_AXI_AWVALID && S_AXI_WVALID && !bvalid;
      bvalid <= wr_hs || (bvalid && !S_AXI_BREADY);
      ar_rdy <= !ar_rdy && S_AXI_ARVALID && !rvalid;
      rvalid <= rd_hs || (rvalid && !S_AXI_RREADY);
      if (rd_hs) rdata <= rd_mux;
      if (wr_hs && wsel == REG_CTRL && wmask[CTRL_EN_BIT]) en <= S_AXI_WDATA[CTRL_EN_BIT];
      if (wr_hs && wsel == REG_THRESH) thresh <= (S_AXI_WDATA[AW:0] & wmask) | (thresh & ~wmask);
      ovf <= !flush && (ovf || (push_req && full && !pop));
      irq <= en && thresh != '0 && level >= thresh;
    end
  end
  scope_sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SAMPLE_WIDTH)) u_fifo (
    .clk(ACLK),
    .rst(ARESET),
    .push(push_req),
    .pop(pop),
    .flush(flush),
    .din(sample_data),
    .dout(dout),
    .level(level),
    .empty(empty),
    .full(full)
  );
  assign S_AXI_AWREADY = aw_rdy;
  assign S_AXI_WREADY = aw_rdy;
  assign S_AXI_BVALID = bvalid;
  assign S_AXI_BRESP = RESP_OKAY;
  assign S_AXI_ARREADY = ar_rdy;
  assign S_AXI_RVALID = rvalid;
  assign S_AXI_RDATA = rdata;
  assign S_AXI_RRESP = RESP_OKAY;
  assign fifo_irq = irq;
endmodule

// File: tb/tb_axil_scope_sample_regs.sv
// tb_axil_scope_sample_regs: directed self-checking bench for axil_scope_sample_regs
module tb_axil_scope_sample_regs;
  logic ACLK = 1'b0, ARESET;
  logic [3:0] S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WSTRB;
  logic [2:0] S_AXI_AWPROT, S_AXI_ARPROT;
  logic S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BREADY;
  logic S_AXI_ARVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic sample_valid, fifo_irq;
  logic [11:0] sample_data;
  int n_tests = 0, n_fail = 0;
  logic [31:0] rd;
  logic [1:0] resp;
  always #5 ACLK = ~ACLK;
  axil_scope_sample_regs dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .sample_valid(sample_valid), .sample_data(sample_data), .fifo_irq(fifo_irq)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic sel_of(input int w);
    return w == 0 ? S_AXI_AWREADY : w == 1 ? S_AXI_BVALID : w == 2 ? S_AXI_ARREADY : S_AXI_RVALID;
  endfunction
  task automatic wait_for(input int w, input string tag);
    int n = 0;
    while (!sel_of(w) && n < 50) begin
      @(posedge ACLK); #1;
      n++;
    end
    check({tag, "_wait"}, 32'(sel_of(w)), 32'd1);
  endtask
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, output logic [1:0] r);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
    wait_for(0, "awready");
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    wait_for(1, "bvalid");
    r = S_AXI_BRESP;
    @(posedge ACLK); #1;
  endtask
  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
    wait_for(2, "arready");
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 0;
    wait_for(3, "rvalid");
    d = S_AXI_RDATA;
    @(posedge ACLK); #1;
  endtask
  task automatic push(input logic [11:0] d);
    sample_data = d; sample_valid = 1;
    @(posedge ACLK); #1;
    sample_valid = 0;
  endtask
  initial begin
    ARESET = 1; S_AXI_AWADDR = 0; S_AXI_ARADDR = 0; S_AXI_WSTRB = 0; S_AXI_AWPROT = 0; S_AXI_ARPROT = 0;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    S_AXI_WDATA = 0; sample_valid = 0; sample_data = 0;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_outs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, fifo_irq}, 0);
    check("rst_rdata", S_AXI_RDATA, 0);
    ARESET = 0;
    @(posedge ACLK); #1;
    axi_read(4'h0, rd); check("rst_ctrl", rd, 32'h0);
    axi_read(4'h4, rd); check("rst_thresh", rd, 32'h0);
    axi_read(4'h8, rd); check("rst_status", rd, 32'h0002_0000);
    axi_read(4'hC, rd); check("rst_data", rd, 32'h0);
    axi_write(4'h0, 32'h1, resp); check("ctrl_bresp", resp, 0);
    axi_write(4'h4, 32'h3, resp); check("thresh_bresp", resp, 0);
    axi_read(4'h0, rd); check("ctrl_rb", rd, 32'h1);
    axi_read(4'h4, rd); check("thresh_rb", rd, 32'h3);
    axi_write(4'h8, 32'hFFFF_FFFF, resp); check("status_wr_bresp", resp, 0);
    axi_read(4'h8, rd); check("status_ro", rd, 32'h0002_0000);
    push(12'h123); push(12'h456);
    @(posedge ACLK); #1;
    check("irq_lvl2", fifo_irq, 0);
    push(12'hABC);
    @(posedge ACLK); #1;
    check("irq_lvl3", fifo_irq, 1);
    axi_read(4'hC, rd); check("data0", rd, 32'h8000_0123);
    check("irq_drop", fifo_irq, 0);
    axi_read(4'hC, rd); check("data1", rd, 32'h8000_0456);
    axi_read(4'hC, rd); check("data2", rd, 32'h8000_0ABC);
    axi_read(4'hC, rd); check("data_empty", rd, 32'h0);
    axi_read(4'h8, rd); check("status_empty", rd, 32'h0002_0000);
    for (int i = 0; i < 17; i++) push(12'(i));
    axi_read(4'h8, rd); check("status_ovf", rd, 32'h0005_0010);
    check("irq_full", fifo_irq, 1);
    axi_write(4'h0, 32'h3, resp);
    axi_read(4'h8, rd); check("status_flush", rd, 32'h0002_0000);
    axi_read(4'h0, rd); check("ctrl_flush_rd0", rd, 32'h1);
    for (int i = 0; i < 16; i++) push(12'h100 + 12'(i));
    axi_read(4'h8, rd); check("status_full", rd, 32'h0004_0010);
    S_AXI_ARADDR = 4'hC; S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
    wait_for(2, "arready_pp");
    sample_data = 12'h777; sample_valid = 1;
    @(posedge ACLK); #1;
    sample_valid = 0; S_AXI_ARVALID = 0;
    wait_for(3, "rvalid_pp");
    check("pp_data", S_AXI_RDATA, 32'h8000_0100);
    @(posedge ACLK); #1;
    axi_read(4'h8, rd); check("pp_status", rd, 32'h0004_0010);
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h5; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 0;
    wait_for(0, "awready_st");
    @(posedge ACLK); #1;
    S_AXI_WDATA = 32'h7;
    for (int i = 0; i < 10; i++) begin
      check("b_hold", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_BRESP}, 4'b1000);
      @(posedge ACLK); #1;
    end
    S_AXI_BREADY = 1;
    wait_for(0, "awready_2nd");
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    wait_for(1, "bvalid_2nd");
    @(posedge ACLK); #1;
    axi_read(4'h4, rd); check("thresh_2nd", rd, 32'h7);
    S_AXI_ARADDR = 4'hC; S_AXI_ARVALID = 1; S_AXI_RREADY = 0;
    wait_for(2, "arready_st");
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 0;
    for (int i = 0; i < 10; i++) begin
      check("r_hold", {S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RRESP}, 4'b1000);
      check("r_data_hold", S_AXI_RDATA, 32'h8000_0101);
      @(posedge ACLK); #1;
    end
    S_AXI_RREADY = 1;
    @(posedge ACLK); #1;
    check("r_done", S_AXI_RVALID, 0);
    axi_read(4'h8, rd); check("single_pop", rd, 32'h0000_000F);
    axi_write(4'h0, 32'h0, resp);
    push(12'h555);
    axi_read(4'h8, rd); check("drop_disabled", rd, 32'h0000_000F);
    check("irq_disabled", fifo_irq, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
